nonce_scheduler: RTL and testbench

// - Sequences a bank of NUM_CORES hash cores for the miner. Splits the 32-bit nonce space into

---
 rtl/nonce_scheduler.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_nonce_scheduler.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : nonce_scheduler
// Description : Sequences a bank of NUM_CORES hash cores. The 32-bit nonce
//               space is cut into chunks of 2^CHUNK_LOG2 nonces that are
//               handed round-robin to idle cores, one start per cycle. The
//               first hit stops the whole bank, latches the winning nonce and
//               raises a one-shot send request. A new block header restarts
//               the search from the supplied nonce.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   NUM_CORES      number of hash cores managed (1..8)
//   CHUNK_LOG2     log2 of nonces per chunk (1..31)
// Build option
//   NONCE_SCHED_STATS_EN  defined   : chunks_done counts accepted core_done
//                                     pulses (popcount per cycle, wraps 2^32)
//                         undefined : chunks_done tied to zero, no counter
// Ports
//   clock           in   single clock, all logic on posedge
//   reset           in   synchronous, active-high
//   hdr_valid       in   1-cycle pulse: new header, restart search
//   hdr_nonce       in   first nonce of the new search (with hdr_valid)
//   core_start      out  1-cycle one-hot pulse: start core i on core_base
//   core_base       out  chunk base nonce, valid while core_start != 0
//   core_abort      out  1-cycle pulse: every core drops its work
//   core_done       in   1-cycle pulse per core: chunk finished, no hit
//   core_hit        in   1-cycle pulse per core: valid hash found
//   core_hit_nonce  in   nonce of core i at [32*i +: 32]
//   found           out  level: winning nonce held in found_nonce
//   found_nonce     out  winning nonce
//   send_req        out  1-cycle pulse, the cycle after found rises
//   exhausted       out  level: whole space issued and finished, no hit
//   busy            out  level: search in progress (DISPATCH)
//   chunks_done     out  completed-chunk count (see build option)
// ============================================================================
module nonce_scheduler #(
   parameter int NUM_CORES  = 4,
   parameter int CHUNK_LOG2 = 16
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    hdr_valid,
   input  logic [31:0]             hdr_nonce,
   output logic [NUM_CORES-1:0]    core_start,
   output logic [31:0]             core_base,
   output logic                    core_abort,
   input  logic [NUM_CORES-1:0]    core_done,
   input  logic [NUM_CORES-1:0]    core_hit,
   input  logic [32*NUM_CORES-1:0] core_hit_nonce,
   output logic                    found,
   output logic [31:0]             found_nonce,
   output logic                    send_req,
   output logic                    exhausted,
   output logic                    busy,
   output logic [31:0]             chunks_done
);

   // Core index width; a single-core bank still gets a 1-bit index.
   localparam int c_IDX_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   // One extra bit so rr + offset can be reduced modulo NUM_CORES.
   localparam int c_CAND_W = c_IDX_W + 1;
   localparam logic [32:0] c_CHUNK = 33'd1 << CHUNK_LOG2;

   localparam logic [1:0] c_IDLE      = 2'd0;
   localparam logic [1:0] c_DISPATCH  = 2'd1;
   localparam logic [1:0] c_FOUND     = 2'd2;
   localparam logic [1:0] c_EXHAUSTED = 2'd3;

   // ---------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------
   logic [1:0]           r_state;
   logic [1:0]           w_stateNext;
   logic [NUM_CORES-1:0] r_coreIdle;
   logic [31:0]          r_nextNonce;
   logic                 r_wrapped;
   logic [c_IDX_W-1:0]   r_rr;
   logic                 r_found;
   logic [31:0]          r_foundNonce;
   logic                 r_hitPend;
   logic                 r_sendReq;
   logic                 r_exhausted;

   // ---------------------------------------------------------------------
   // Combinational helpers
   // ---------------------------------------------------------------------
   logic                 w_inDispatch;
   logic                 w_hitAccept;
   logic                 w_exhaustNow;
   logic                 w_startEn;
   logic                 w_pickValid;
   logic [c_IDX_W-1:0]   w_pickIdx;
   logic [c_CAND_W-1:0]  w_cand;
   logic [c_CAND_W-1:0]  w_rrSum;
   logic [c_IDX_W-1:0]   w_rrNext;
   logic [31:0]          w_hitNonce;
   logic [NUM_CORES-1:0] w_doneAccept;
   logic [NUM_CORES-1:0] w_idleNext;
   logic [32:0]          w_nonceSum;

   assign w_inDispatch = (r_state == c_DISPATCH);

   // A header overrides everything else happening in the same cycle, so a
   // hit is only taken when no header arrives alongside it.
   assign w_hitAccept  = w_inDispatch & ~hdr_valid & (|core_hit);

   // Space fully handed out and every core back to idle: nothing left to do.
   assign w_exhaustNow = w_inDispatch & ~hdr_valid & ~w_hitAccept &
                         r_wrapped & (&r_coreIdle);

   // Dones only count for cores that are actually working, and are dropped
   // on header/hit cycles because the whole bank is aborted anyway.
   assign w_doneAccept = (w_inDispatch & ~hdr_valid & ~w_hitAccept) ?
                         (core_done & ~r_coreIdle) : '0;

   // The carry out of this 33-bit add marks the end of the nonce space.
   assign w_nonceSum   = {1'b0, r_nextNonce} + c_CHUNK;

   // ---------------------------------------------------------------------
   // Round-robin pick: first idle core at or after r_rr, circularly.
   // Walk the offsets from farthest to nearest so the nearest idle core is
   // the one left in w_pickIdx.
   // ---------------------------------------------------------------------
   always_comb begin
      w_pickValid = 1'b0;
      w_pickIdx   = '0;
      w_cand      = '0;
      for (int k = NUM_CORES - 1; k >= 0; k--) begin
         w_cand = {1'b0, r_rr} + c_CAND_W'(k);
         if (w_cand >= c_CAND_W'(NUM_CORES)) begin
            w_cand = w_cand - c_CAND_W'(NUM_CORES);
         end
         if (r_coreIdle[w_cand[c_IDX_W-1:0]]) begin
            w_pickValid = 1'b1;
            w_pickIdx   = w_cand[c_IDX_W-1:0];
         end
      end
   end

   // Pointer moves to the core after the one just started.
   always_comb begin
      w_rrSum = {1'b0, w_pickIdx} + c_CAND_W'(1);
      if (w_rrSum >= c_CAND_W'(NUM_CORES)) begin
         w_rrSum = w_rrSum - c_CAND_W'(NUM_CORES);
      end
      w_rrNext = w_rrSum[c_IDX_W-1:0];
   end

   // Lowest-index hitting core wins: scan downward so it is written last.
   always_comb begin
      w_hitNonce = '0;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         if (core_hit[i]) begin
            w_hitNonce = core_hit_nonce[32*i +: 32];
         end
      end
   end

   // Idle mask update. A core started this cycle is busy even if a done for
   // it shows up in the same cycle (that done was for an idle core and is
   // already filtered out of w_doneAccept).
   always_comb begin
      if (hdr_valid || w_hitAccept) begin
         w_idleNext = '1;
      end else begin
         w_idleNext = (r_coreIdle | w_doneAccept) & ~core_start;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      w_stateNext = r_state;
      if (hdr_valid) begin
         w_stateNext = c_DISPATCH;
      end else begin
         case (r_state)
            c_DISPATCH: begin
               if (w_hitAccept) begin
                  w_stateNext = c_FOUND;
               end else if (w_exhaustNow) begin
                  w_stateNext = c_EXHAUSTED;
               end
            end
            default: w_stateNext = r_state;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // FSM: output logic (start/abort are same-cycle pulses)
   // ---------------------------------------------------------------------
   always_comb begin
      busy       = w_inDispatch;
      core_abort = ~reset & (hdr_valid | w_hitAccept);
      // Any hit line, even one from an idle core, blocks a start that cycle.
      w_startEn  = w_inDispatch & ~hdr_valid & ~(|core_hit) &
                   ~r_wrapped & w_pickValid;
      core_start = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         core_start[i] = w_startEn & (w_pickIdx == c_IDX_W'(i));
      end
      core_base = '0;
      if (w_startEn) begin
         core_base = r_nextNonce;
      end
   end

   // ---------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         r_coreIdle   <= '1;
         r_nextNonce  <= '0;
         r_wrapped    <= 1'b0;
         r_rr         <= '0;
         r_found      <= 1'b0;
         r_foundNonce <= '0;
         r_hitPend    <= 1'b0;
         r_sendReq    <= 1'b0;
         r_exhausted  <= 1'b0;
      end else begin
         r_coreIdle <= w_idleNext;
         // send_req trails the found rise by one cycle.
         r_hitPend  <= w_hitAccept;
         r_sendReq  <= r_hitPend;
         if (hdr_valid) begin
            r_nextNonce <= hdr_nonce;
            r_wrapped   <= 1'b0;
            r_rr        <= '0;
            r_found     <= 1'b0;
            r_exhausted <= 1'b0;
         end else begin
            if (w_startEn) begin
               r_nextNonce <= w_nonceSum[31:0];
               r_wrapped   <= w_nonceSum[32];
               r_rr        <= w_rrNext;
            end
            if (w_hitAccept) begin
               r_found      <= 1'b1;
               r_foundNonce <= w_hitNonce;
            end
            if (w_exhaustNow) begin
               r_exhausted <= 1'b1;
            end
         end
      end
   end

   assign found       = r_found;
   assign found_nonce = r_foundNonce;
   assign send_req    = r_sendReq;
   assign exhausted   = r_exhausted;

   // ---------------------------------------------------------------------
   // Completed-chunk statistics
   // ---------------------------------------------------------------------
`ifdef NONCE_SCHED_STATS_EN
   logic [31:0] r_chunksDone;
   logic [31:0] w_doneCount;

   always_comb begin
      w_doneCount = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         w_doneCount = w_doneCount + 32'(w_doneAccept[i]);
      end
   end

   // Not cleared by a new header; only reset clears it.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_chunksDone <= '0;
      end else begin
         r_chunksDone <= r_chunksDone + w_doneCount;
      end
   end

   assign chunks_done = r_chunksDone;
`else
   assign chunks_done = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nonce_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_nonce_scheduler
// Description : Self-checking bench for nonce_scheduler. Directed scenarios
//               followed by randomized traffic, every cycle compared against
//               a behavioural model of the scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nonce_scheduler;

   localparam int NC = 4;
   localparam int CL = 16;

   logic              clock = 1'b0;
   logic              reset;
   logic              hdr_valid;
   logic [31:0]       hdr_nonce;
   logic [NC-1:0]     core_start;
   logic [31:0]       core_base;
   logic              core_abort;
   logic [NC-1:0]     core_done;
   logic [NC-1:0]     core_hit;
   logic [32*NC-1:0]  core_hit_nonce;
   logic              found;
   logic [31:0]       found_nonce;
   logic              send_req;
   logic              exhausted;
   logic              busy;
   logic [31:0]       chunks_done;

   always #5 clock = ~clock;

   nonce_scheduler #(
      .NUM_CORES  (NC),
      .CHUNK_LOG2 (CL)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .hdr_valid      (hdr_valid),
      .hdr_nonce      (hdr_nonce),
      .core_start     (core_start),
      .core_base      (core_base),
      .core_abort     (core_abort),
      .core_done      (core_done),
      .core_hit       (core_hit),
      .core_hit_nonce (core_hit_nonce),
      .found          (found),
      .found_nonce    (found_nonce),
      .send_req       (send_req),
      .exhausted      (exhausted),
      .busy           (busy),
      .chunks_done    (chunks_done)
   );

   int assertCount = 0;
   int failCount   = 0;

   task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      assertCount++;
      if (obs !== exp) begin
         failCount++;
         $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", tag, $time, obs, exp);
      end
   endtask

   // ---------------------------------------------------------------------
   // Behavioural model: per-core busy flags, next nonce as a wide integer
   // (space is issued once it reaches 2^32), phase of the search.
   // ---------------------------------------------------------------------
   localparam int PH_IDLE = 0, PH_SEARCH = 1, PH_FOUND = 2, PH_EXH = 3;
   int              mPhase;
   bit              mBusy[NC];
   longint unsigned mNext;
   int              mRr;
   bit              mFound;
   logic [31:0]     mFoundNonce;
   bit              mSendPend;
   bit              mSendNow;
   bit              mExh;
   logic [31:0]     mChunks;

   // Observed values of the last step, for directed checks.
   logic [NC-1:0]   oStart;
   logic [31:0]     oBase;
   logic            oAbort, oFound, oSend, oExh, oBusy;
   logic [31:0]     oFoundNonce, oChunks;

   task automatic modelReset();
      mPhase = PH_IDLE;
      for (int i = 0; i < NC; i++) mBusy[i] = 1'b0;
      mNext = 0; mRr = 0; mFound = 0; mFoundNonce = '0;
      mSendPend = 0; mSendNow = 0; mExh = 0; mChunks = '0;
   endtask

   // One clock cycle: drive at negedge, compare shortly after, then advance
   // the model to what the following posedge should produce.
   task automatic step(input bit hdr, input logic [31:0] nonce, input logic [NC-1:0] done,
                       input logic [NC-1:0] hit, input logic [32*NC-1:0] hitN);
      bit            inSearch, hitAcc, issued, allFree, canStart, exhaust;
      int            pick;
      logic [NC-1:0] one, expStart;
      logic [31:0]   expChunks;
      @(negedge clock);
      hdr_valid = hdr; hdr_nonce = nonce; core_done = done;
      core_hit = hit; core_hit_nonce = hitN;
      #1;
      oStart = core_start; oBase = core_base; oAbort = core_abort;
      oFound = found; oFoundNonce = found_nonce; oSend = send_req;
      oExh = exhausted; oBusy = busy; oChunks = chunks_done;

      inSearch = (mPhase == PH_SEARCH);
      hitAcc   = inSearch && !hdr && (hit != '0);
      issued   = (mNext >= 64'h1_0000_0000);
      allFree  = 1'b1;
      for (int i = 0; i < NC; i++) if (mBusy[i]) allFree = 1'b0;
      pick = -1;
      for (int k = 0; k < NC; k++) begin
         int c = (mRr + k) % NC;
         if (pick < 0 && !mBusy[c]) pick = c;
      end
      canStart = inSearch && !hdr && (hit == '0) && !issued && (pick >= 0);
      one      = 1;
      expStart = canStart ? (one << pick) : '0;
`ifdef NONCE_SCHED_STATS_EN
      expChunks = mChunks;
`else
      expChunks = 32'h0;
`endif
      checkEq("core_start", 64'(oStart), 64'(expStart));
      if (canStart) checkEq("core_base", 64'(oBase), 64'(mNext[31:0]));
      checkEq("core_abort", 64'(oAbort), 64'(hdr || hitAcc));
      checkEq("busy", 64'(oBusy), 64'(inSearch));
      checkEq("found", 64'(oFound), 64'(mFound));
      checkEq("found_nonce", 64'(oFoundNonce), 64'(mFoundNonce));
      checkEq("send_req", 64'(oSend), 64'(mSendNow));
      checkEq("exhausted", 64'(oExh), 64'(mExh));
      checkEq("chunks_done", 64'(oChunks), 64'(expChunks));

      exhaust   = inSearch && !hdr && !hitAcc && issued && allFree;
      mSendNow  = mSendPend;
      mSendPend = hitAcc;
      if (hdr) begin
         mPhase = PH_SEARCH; mFound = 0; mExh = 0; mNext = 64'(nonce); mRr = 0;
         for (int i = 0; i < NC; i++) mBusy[i] = 1'b0;
      end else if (hitAcc) begin
         for (int i = NC - 1; i >= 0; i--) if (hit[i]) mFoundNonce = hitN[32*i +: 32];
         mFound = 1; mPhase = PH_FOUND;
         for (int i = 0; i < NC; i++) mBusy[i] = 1'b0;
      end else if (inSearch) begin
         for (int i = 0; i < NC; i++) begin
            if (done[i] && mBusy[i]) begin
               mBusy[i] = 1'b0;
               mChunks  = mChunks + 32'd1;
            end
         end
         if (canStart) begin
            mBusy[pick] = 1'b1;
            mRr   = (pick + 1) % NC;
            mNext = mNext + (64'd1 << CL);
         end
         if (exhaust) begin
            mExh = 1; mPhase = PH_EXH;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, '0, '0, '0, '0);
   endtask

   logic [32*NC-1:0] hn;
   logic [NC-1:0]    rDone, rHit;
   logic [31:0]      rNonce, tmp;
   bit               rHdr;

   initial begin
      reset = 1; hdr_valid = 0; hdr_nonce = '0; core_done = '0;
      core_hit = '0; core_hit_nonce = '0;
      repeat (3) @(negedge clock);
      #1;
      checkEq("rst_start", 64'(core_start), 64'h0);
      checkEq("rst_abort", 64'(core_abort), 64'h0);
      checkEq("rst_found", 64'(found), 64'h0);
      checkEq("rst_found_nonce", 64'(found_nonce), 64'h0);
      checkEq("rst_send", 64'(send_req), 64'h0);
      checkEq("rst_exhausted", 64'(exhausted), 64'h0);
      checkEq("rst_busy", 64'(busy), 64'h0);
      checkEq("rst_chunks", 64'(chunks_done), 64'h0);
      reset = 0;
      modelReset();

      // Header at nonce 0: four starts on consecutive cycles.
      step(1, 32'h0, '0, '0, '0);
      checkEq("dir_hdr_abort", 64'(oAbort), 64'h1);
      for (int k = 0; k < 4; k++) begin
         idle(1);
         checkEq("dir_start_seq", 64'(oStart), 64'(4'b0001 << k));
         checkEq("dir_base_seq", 64'(oBase), 64'(k) << 16);
      end
      // Core 2 done, restarted the cycle after with the next chunk.
      step(0, '0, 4'b0100, '0, '0);
      checkEq("dir_nostart_full", 64'(oStart), 64'h0);
      idle(1);
      checkEq("dir_restart2", 64'(oStart), 64'h4);
      checkEq("dir_restart2_base", 64'(oBase), 64'h40000);
      idle(1);
      // Two hits in one cycle: core 1 (lower index) wins.
      hn = '0; hn[32*1 +: 32] = 32'h42A14695; hn[32*3 +: 32] = 32'hAAAA0001;
      step(0, '0, '0, 4'b1010, hn);
      checkEq("dir_hit_abort", 64'(oAbort), 64'h1);
      checkEq("dir_hit_nostart", 64'(oStart), 64'h0);
      idle(1);
      checkEq("dir_found", 64'(oFound), 64'h1);
      checkEq("dir_found_nonce", 64'(oFoundNonce), 64'h42A14695);
      checkEq("dir_send_early", 64'(oSend), 64'h0);
      idle(1);
      checkEq("dir_send", 64'(oSend), 64'h1);
      idle(1);
      checkEq("dir_send_once", 64'(oSend), 64'h0);

      // Four chunks left before the top of the space.
      step(1, 32'hFFFC0000, '0, '0, '0);
      idle(4);
      checkEq("dir_last_base", 64'(oBase), 64'hFFFF0000);
      step(0, '0, 4'b1111, '0, '0);
      idle(1);
      idle(1);
      checkEq("dir_exhausted", 64'(oExh), 64'h1);
      checkEq("dir_exh_busy", 64'(oBusy), 64'h0);
      idle(3);
      checkEq("dir_exh_nostart", 64'(oStart), 64'h0);
      checkEq("dir_exh_nosend", 64'(oSend), 64'h0);

      // Header together with a hit: the hit is discarded.
      step(1, 32'h50000000, '0, '0, '0);
      idle(1);
      hn = '0; hn[31:0] = 32'hDEADBEEF;
      step(1, 32'h12340000, '0, 4'b0001, hn);
      checkEq("dir_hdrhit_abort", 64'(oAbort), 64'h1);
      idle(1);
      checkEq("dir_hdrhit_nofound", 64'(oFound), 64'h0);
      checkEq("dir_hdrhit_start", 64'(oStart), 64'h1);
      checkEq("dir_hdrhit_base", 64'(oBase), 64'h12340000);
      idle(3);
`ifdef NONCE_SCHED_STATS_EN
      checkEq("dir_chunks_pre", 64'(oChunks), 64'd5);
`else
      checkEq("dir_chunks_pre", 64'(oChunks), 64'd0);
`endif
      // Five single dones and one double done.
      step(0, '0, 4'b0001, '0, '0); idle(1);
      step(0, '0, 4'b0010, '0, '0); idle(1);
      step(0, '0, 4'b0100, '0, '0); idle(1);
      step(0, '0, 4'b1000, '0, '0); idle(1);
      step(0, '0, 4'b0001, '0, '0); idle(1);
      step(0, '0, 4'b0110, '0, '0); idle(1);
`ifdef NONCE_SCHED_STATS_EN
      checkEq("dir_chunks_post", 64'(oChunks), 64'd12);
`else
      checkEq("dir_chunks_post", 64'(oChunks), 64'd0);
`endif

      // Randomized traffic.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         rHdr = (mPhase != PH_SEARCH) ? ($urandom_range(0, 7) == 0)
                                      : ($urandom_range(0, 199) == 0);
         case ($urandom_range(0, 3))
            0: rNonce = $urandom;
            1: rNonce = 32'hFFFFFFFF;
            default: begin
               tmp    = 32'($urandom_range(1, 12));
               rNonce = (32'h0 - (tmp << 16)) + 32'($urandom_range(0, 65535));
            end
         endcase
         rDone = '0;
         for (int i = 0; i < NC; i++) begin
            if (mBusy[i] && $urandom_range(0, 5) == 0) rDone[i] = 1'b1;
            else if ($urandom_range(0, 49) == 0) rDone[i] = 1'b1;
         end
         rHit = '0;
         if ($urandom_range(0, 99) == 0) rHit = NC'($urandom_range(1, 15));
         for (int i = 0; i < NC; i++) hn[32*i +: 32] = $urandom;
         step(rHdr, rNonce, rDone, rHit, hn);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
`default_nettype wire
